// File: rtl/display_scan_controller.sv
// Scans one shared BCD-to-7-segment decoder across DIGITS common-anode digits,
// with a tear-free double buffer updated only at frame boundaries.
module display_scan_controller #(
    parameter int unsigned DIGITS       = 4,
    parameter int unsigned PRESCALE     = 50000,
    parameter int unsigned BLANK_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enable,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   digits,
    input  logic [DIGITS-1:0]     blank,
    output logic [3:0]            bcd,
    output logic [DIGITS-1:0]     digit_sel,
    output logic                  frame_tick,
    output logic                  update_done
);

    localparam int unsigned IDX_W   = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int unsigned CNT_MAX = (PRESCALE > BLANK_CYCLES) ? PRESCALE : BLANK_CYCLES;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] SHOW = 2'd1;
    localparam logic [1:0] GAP  = 2'd2;

    logic [1:0]            state, state_n;
    logic [IDX_W-1:0]      idx, idx_n;
    logic [CNT_W-1:0]      cnt, cnt_n;
    logic                  pending;
    logic [4*DIGITS-1:0]   shadow, active, view_digits;
    logic [DIGITS-1:0]     shadow_blank, active_blank, view_blank;
    logic                  advance, boundary, apply;
    logic [3:0]            code;
    logic [3:0]            bcd_n;
    logic [DIGITS-1:0]     sel_n;

    // Next-state, slot sequencing and next registered outputs
    always_comb begin
        state_n     = state;
        idx_n       = idx;
        cnt_n       = cnt;
        advance     = 1'b0;
        boundary    = 1'b0;
        apply       = 1'b0;
        view_digits = active;
        view_blank  = active_blank;
        code        = 4'h0;
        bcd_n       = bcd;
        sel_n       = '1;

        case (state)
            IDLE: begin
                if (enable) begin
                    state_n = SHOW;
                    idx_n   = '0;
                    cnt_n   = '0;
                end
            end
            SHOW: begin
                if (cnt == CNT_W'(PRESCALE - 1)) begin
                    cnt_n = '0;
                    if (BLANK_CYCLES > 0) state_n = GAP;
                    else                  advance = 1'b1;
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
            GAP: begin
                if (cnt == CNT_W'(BLANK_CYCLES - 1)) begin
                    cnt_n   = '0;
                    state_n = SHOW;
                    advance = 1'b1;
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
            default: state_n = IDLE;
        endcase

        if (advance) begin
            if (idx == IDX_W'(DIGITS - 1)) begin
                idx_n    = '0;
                boundary = 1'b1;
            end else begin
                idx_n = idx + IDX_W'(1);
            end
        end

        if (!enable) begin
            state_n  = IDLE;
            idx_n    = '0;
            cnt_n    = '0;
            boundary = 1'b0;
        end

        // A boundary update is shown in the very slot it lands in
        apply = boundary && pending;
        if (apply) begin
            view_digits = shadow;
            view_blank  = shadow_blank;
        end

        if (state_n == SHOW) begin
            code  = view_digits[{idx_n, 2'b00} +: 4];
            bcd_n = code;
            if (!view_blank[idx_n] && (code <= 4'd9)) sel_n[idx_n] = 1'b0;
        end
    end

    // State, buffers and registered outputs; active blank mask resets dark so nothing lights before the first update
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            idx          <= '0;
            cnt          <= '0;
            pending      <= 1'b0;
            shadow       <= '0;
            shadow_blank <= '0;
            active       <= '0;
            active_blank <= '1;
            bcd          <= 4'h0;
            digit_sel    <= '1;
            frame_tick   <= 1'b0;
            update_done  <= 1'b0;
        end else begin
            state       <= state_n;
            idx         <= idx_n;
            cnt         <= cnt_n;
            bcd         <= bcd_n;
            digit_sel   <= sel_n;
            frame_tick  <= boundary;
            update_done <= apply;
            pending     <= load | (pending & ~apply);
            if (load) begin
                shadow       <= digits;
                shadow_blank <= blank;
            end
            if (apply) begin
                active       <= shadow;
                active_blank <= shadow_blank;
            end
        end
    end

endmodule

// File: tb/tb_display_scan_controller.sv
// Directed bench for display_scan_controller: u0 with one gap cycle per slot, u1 with none.
module tb_display_scan_controller;

    logic        clk;
    logic        rst_n;
    logic        enable;
    logic        load;
    logic [15:0] digits;
    logic [3:0]  blank;
    logic [3:0]  bcd0, bcd1, sel0, sel1;
    logic        ft0, ft1, ud0, ud1;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [15:0] digits;
        logic [3:0]  blank;
        logic [15:0] sel;   // expected lit pattern per slot, nibble i = slot i
        logic [15:0] bcd;   // expected code per slot
    } vec_t;

    vec_t vecs[4];

    display_scan_controller #(.DIGITS(4), .PRESCALE(4), .BLANK_CYCLES(1)) u0 (
        .clk(clk), .rst_n(rst_n), .enable(enable), .load(load), .digits(digits), .blank(blank),
        .bcd(bcd0), .digit_sel(sel0), .frame_tick(ft0), .update_done(ud0)
    );

    display_scan_controller #(.DIGITS(4), .PRESCALE(4), .BLANK_CYCLES(0)) u1 (
        .clk(clk), .rst_n(rst_n), .enable(enable), .load(load), .digits(digits), .blank(blank),
        .bcd(bcd1), .digit_sel(sel1), .frame_tick(ft1), .update_done(ud1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s t=%0t got=%h want=%h", name, $time, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Checks one 20-cycle frame of u0, optionally issuing up to two loads at given cycles
    task automatic run_frame(input logic [15:0] esel, input logic [15:0] ebcd,
                             input logic eft, input logic eud,
                             input int la, input logic [15:0] lda,
                             input int lb, input logic [15:0] ldb, input logic [3:0] lblank);
        for (int c = 0; c < 20; c++) begin
            int slot;
            int ph;
            slot = c / 5;
            ph   = c % 5;
            chk("sel", 16'(sel0), (ph < 4) ? 16'(esel[slot*4 +: 4]) : 16'h000F);
            chk("bcd", 16'(bcd0), 16'(ebcd[slot*4 +: 4]));
            chk("frame_tick", 16'(ft0), (c == 0) ? 16'(eft) : 16'h0000);
            chk("update_done", 16'(ud0), (c == 0) ? 16'(eud) : 16'h0000);
            load = 1'b0;
            if (c == la) begin load = 1'b1; digits = lda; blank = lblank; end
            if (c == lb) begin load = 1'b1; digits = ldb; blank = lblank; end
            tick();
        end
        load = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; enable = 1'b0; load = 1'b0; digits = 16'h0; blank = 4'h0;
        vecs[0] = '{digits: 16'h4321, blank: 4'b0000, sel: 16'h7BDE, bcd: 16'h4321};
        vecs[1] = '{digits: 16'h9876, blank: 4'b0000, sel: 16'h7BDE, bcd: 16'h9876};
        vecs[2] = '{digits: 16'h73C0, blank: 4'b0100, sel: 16'h7FFE, bcd: 16'h73C0};
        vecs[3] = '{digits: 16'h0A05, blank: 4'b0000, sel: 16'h7FDE, bcd: 16'h0A05};

        repeat (2) @(posedge clk);
        #1;
        chk("rst_sel0", 16'(sel0), 16'h000F);
        chk("rst_bcd0", 16'(bcd0), 16'h0000);
        chk("rst_ft0",  16'(ft0),  16'h0000);
        chk("rst_ud0",  16'(ud0),  16'h0000);
        chk("rst_sel1", 16'(sel1), 16'h000F);
        rst_n = 1'b1;
        tick();

        // Load in IDLE, then start scanning; first frame stays dark
        load = 1'b1; digits = 16'h4321; blank = 4'h0;
        tick();
        load = 1'b0;
        chk("idle_sel", 16'(sel0), 16'h000F);
        enable = 1'b1;
        tick();
        run_frame(16'hFFFF, 16'h0000, 1'b0, 1'b0, -1, 16'h0, -1, 16'h0, 4'h0);

        // Table: each frame shows one vector while the next is loaded mid-frame
        for (int i = 0; i < 4; i++) begin
            int nx;
            nx = (i < 3) ? i + 1 : i;
            run_frame(vecs[i].sel, vecs[i].bcd, 1'b1, 1'b1, (i < 3) ? 7 : -1,
                      vecs[nx].digits, -1, 16'h0, vecs[nx].blank);
        end

        // Load 1111 early, then 2222 on the boundary edge
        run_frame(vecs[3].sel, vecs[3].bcd, 1'b1, 1'b0, 3, 16'h1111, 19, 16'h2222, 4'h0);
        run_frame(16'h7BDE, 16'h1111, 1'b1, 1'b1, -1, 16'h0, -1, 16'h0, 4'h0);
        run_frame(16'h7BDE, 16'h2222, 1'b1, 1'b1, -1, 16'h0, -1, 16'h0, 4'h0);

        // Enable drop during slot 2, load while idle, restart
        repeat (10) tick();
        chk("slot2_sel", 16'(sel0), 16'h000B);
        chk("slot2_bcd", 16'(bcd0), 16'h0002);
        enable = 1'b0;
        tick();
        chk("drop_sel", 16'(sel0), 16'h000F);
        chk("drop_ft",  16'(ft0),  16'h0000);
        load = 1'b1; digits = 16'h3333; blank = 4'h0;
        tick();
        load = 1'b0;
        chk("idle_sel2", 16'(sel0), 16'h000F);
        tick();
        chk("idle_sel3", 16'(sel0), 16'h000F);
        enable = 1'b1;
        tick();
        run_frame(16'h7BDE, 16'h2222, 1'b0, 1'b0, -1, 16'h0, -1, 16'h0, 4'h0);
        run_frame(16'h7BDE, 16'h3333, 1'b1, 1'b1, -1, 16'h0, -1, 16'h0, 4'h0);

        // Asynchronous reset mid-slot darkens immediately
        repeat (3) tick();
        chk("pre_rst_sel", 16'(sel0), 16'h000E);
        rst_n  = 1'b0;
        enable = 1'b0;
        #1;
        chk("async_rst_sel0", 16'(sel0), 16'h000F);
        chk("async_rst_bcd0", 16'(bcd0), 16'h0000);
        chk("async_rst_sel1", 16'(sel1), 16'h000F);
        tick();
        rst_n = 1'b1;
        tick();

        // No gap cycles: back-to-back slots, 16-cycle frames
        load = 1'b1; digits = 16'h4321; blank = 4'h0;
        tick();
        load = 1'b0;
        enable = 1'b1;
        tick();
        for (int c = 0; c < 16; c++) begin
            chk("nogap_dark_sel", 16'(sel1), 16'h000F);
            chk("nogap_dark_ft",  16'(ft1),  16'h0000);
            tick();
        end
        for (int f = 0; f < 2; f++) begin
            for (int c = 0; c < 16; c++) begin
                logic [15:0] es;
                logic [15:0] eb;
                es = 16'h7BDE;
                eb = 16'h4321;
                chk("nogap_sel", 16'(sel1), 16'(es[(c/4)*4 +: 4]));
                chk("nogap_bcd", 16'(bcd1), 16'(eb[(c/4)*4 +: 4]));
                chk("nogap_ft",  16'(ft1),  (c == 0) ? 16'h0001 : 16'h0000);
                chk("nogap_ud",  16'(ud1),  (c == 0 && f == 0) ? 16'h0001 : 16'h0000);
                tick();
            end
        end
        chk("nogap_ft_end", 16'(ft1), 16'h0001);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
